// File: rtl/fsm_cfg_pkg.sv
// Shared definitions for the config-bus initiator: FSM state encoding, response
// status codes and the address of the FSM config register.
package fsm_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCESS = 3'd1,
        GAP    = 3'd2,
        VERIFY = 3'd3,
        RESP   = 3'd4
    } state_t;

    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_TIMEOUT  = 2'b01;
    localparam logic [1:0] ST_MISMATCH = 2'b10;

    localparam logic [31:0] FSM_CFG_ADDR = 32'h1000_0000;

    // Expands byte enables into a 32-bit bit mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] strb);
        lane_mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage

// File: rtl/cfg_timeout_ctr.sv
// Saturating bus-wait counter with synchronous clear and count enable;
// expired is high once the count equals TIMEOUT_CYCLES.
module cfg_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/fsm_cfg_initiator.sv
// Native-bus initiator: runs single read/write commands, with optional
// write-then-readback verify, and returns a status/data response.
module fsm_cfg_initiator
    import fsm_cfg_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 16,
    parameter logic [31:0] VERIFY_MASK    = 32'h0000_000F
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,
    input  logic        cmd_verify,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_status,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    state_t      state, state_d;
    logic        mem_valid_d, rsp_valid_d, cmd_ready_d, busy_d;
    logic [31:0] mem_addr_d, mem_wdata_d, rsp_rdata_d;
    logic [3:0]  mem_wstrb_d;
    logic [1:0]  rsp_status_d;
    logic        lat_write, lat_write_d, lat_verify, lat_verify_d;
    logic [31:0] lat_wdata, lat_wdata_d;
    logic [3:0]  lat_wstrb, lat_wstrb_d;
    logic        ctr_en, ctr_clr, expired;
    logic [31:0] verify_bits;

    cfg_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .resetn  (resetn),
        .clr     (ctr_clr),
        .en      (ctr_en),
        .expired (expired)
    );

    assign verify_bits = VERIFY_MASK & lane_mask(lat_wstrb);

    always_comb begin
        state_d      = state;
        mem_valid_d  = mem_valid;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        mem_wstrb_d  = mem_wstrb;
        rsp_valid_d  = rsp_valid;
        rsp_rdata_d  = rsp_rdata;
        rsp_status_d = rsp_status;
        lat_write_d  = lat_write;
        lat_verify_d = lat_verify;
        lat_wdata_d  = lat_wdata;
        lat_wstrb_d  = lat_wstrb;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_d      = ACCESS;
                    mem_valid_d  = 1'b1;
                    mem_addr_d   = cmd_addr;
                    mem_wdata_d  = cmd_write ? cmd_wdata : 32'h0;
                    mem_wstrb_d  = cmd_write ? cmd_wstrb : 4'b0000;
                    lat_write_d  = cmd_write;
                    lat_verify_d = cmd_write & cmd_verify;
                    lat_wdata_d  = cmd_wdata;
                    lat_wstrb_d  = cmd_wstrb;
                end
            end
            ACCESS: begin
                // Ready wins over a simultaneous expiry.
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    if (lat_verify) begin
                        state_d = GAP;
                    end else begin
                        state_d      = RESP;
                        rsp_valid_d  = 1'b1;
                        rsp_status_d = ST_OK;
                        rsp_rdata_d  = lat_write ? 32'h0 : mem_rdata;
                    end
                end else if (expired) begin
                    mem_valid_d  = 1'b0;
                    state_d      = RESP;
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = ST_TIMEOUT;
                    rsp_rdata_d  = 32'h0;
                end
            end
            GAP: begin
                state_d     = VERIFY;
                mem_valid_d = 1'b1;
                mem_wdata_d = 32'h0;
                mem_wstrb_d = 4'b0000;
            end
            VERIFY: begin
                if (mem_ready) begin
                    mem_valid_d  = 1'b0;
                    state_d      = RESP;
                    rsp_valid_d  = 1'b1;
                    rsp_rdata_d  = mem_rdata;
                    rsp_status_d = (((mem_rdata ^ lat_wdata) & verify_bits) == 32'h0)
                                   ? ST_OK : ST_MISMATCH;
                end else if (expired) begin
                    mem_valid_d  = 1'b0;
                    state_d      = RESP;
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = ST_TIMEOUT;
                    rsp_rdata_d  = 32'h0;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Counter tracks edges at which mem_valid is (or becomes) high.
        ctr_en      = (state_d == ACCESS) || (state_d == VERIFY);
        ctr_clr     = !ctr_en;
        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            mem_valid  <= 1'b0;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
            mem_wstrb  <= 4'b0000;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'h0;
            rsp_status <= ST_OK;
            lat_write  <= 1'b0;
            lat_verify <= 1'b0;
            lat_wdata  <= 32'h0;
            lat_wstrb  <= 4'b0000;
        end else begin
            state      <= state_d;
            cmd_ready  <= cmd_ready_d;
            busy       <= busy_d;
            mem_valid  <= mem_valid_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            mem_wstrb  <= mem_wstrb_d;
            rsp_valid  <= rsp_valid_d;
            rsp_rdata  <= rsp_rdata_d;
            rsp_status <= rsp_status_d;
            lat_write  <= lat_write_d;
            lat_verify <= lat_verify_d;
            lat_wdata  <= lat_wdata_d;
            lat_wstrb  <= lat_wstrb_d;
        end
    end

endmodule

// File: tb/tb_fsm_cfg_initiator.sv
// Bench for fsm_cfg_initiator with a config-responder model and a response
// scoreboard.
module tb_fsm_cfg_initiator;
    import fsm_cfg_pkg::*;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0, cmd_verify = 1'b0;
    logic [31:0] cmd_addr = 32'h0, cmd_wdata = 32'h0;
    logic [3:0]  cmd_wstrb = 4'h0;
    logic        cmd_ready;
    logic        rsp_valid, rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_status;
    logic        mem_valid, mem_ready = 1'b0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        busy;

    fsm_cfg_initiator #(.TIMEOUT_CYCLES(TO), .VERIFY_MASK(32'h0000_000F)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .cmd_verify(cmd_verify),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_status(rsp_status),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Config responder: ready one cycle after valid, optional trailing ready.
    logic [3:0]  fsm_config = 4'h0;
    logic        trail = 1'b0, force_rb = 1'b0;
    logic [31:0] force_val = 32'h0;
    int          beats = 0;

    assign mem_rdata = force_rb ? force_val : {28'h0, fsm_config};

    always @(posedge clk) begin
        if (mem_valid && mem_ready) begin
            beats <= beats + 1;
            if (mem_wstrb[0]) fsm_config <= mem_wdata[3:0];
            mem_ready <= trail;
        end else if (mem_valid && mem_addr == FSM_CFG_ADDR) begin
            mem_ready <= 1'b1;
        end else begin
            mem_ready <= 1'b0;
        end
    end

    // Bus monitor: length of each request and idle gap before it.
    logic        prev_v = 1'b0;
    int          run = 0, gap = 0, last_run = 0, last_gap = 0;
    logic [3:0]  last_wstrb = 4'h0;
    logic [31:0] last_wdata = 32'h0;

    always @(negedge clk) begin
        if (mem_valid) begin
            if (!prev_v) begin
                last_gap   = gap;
                last_wstrb = mem_wstrb;
                last_wdata = mem_wdata;
                run        = 0;
            end
            run++;
        end else begin
            if (prev_v) last_run = run;
            gap = prev_v ? 1 : gap + 1;
        end
        prev_v = mem_valid;
    end

    typedef struct packed {
        logic [1:0]  st;
        logic [31:0] rd;
    } exp_t;
    exp_t sb[$];
    int   n_rsp = 0;

    always @(negedge clk) begin
        if (resetn && rsp_valid && rsp_ready) begin
            exp_t e;
            n_rsp++;
            if (sb.size() == 0) begin
                check_eq("unexpected_rsp", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check_eq("rsp_status", 64'(rsp_status), 64'(e.st));
                check_eq("rsp_rdata", 64'(rsp_rdata), 64'(e.rd));
            end
        end
    end

    task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input bit ver, input bit exp_rsp,
                         input logic [1:0] est, input logic [31:0] erd);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            check_eq("cmd_ready_wait", 64'd0, 64'd1);
            return;
        end
        if (exp_rsp) sb.push_back('{st: est, rd: erd});
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a;
        cmd_wdata = d; cmd_wstrb = s; cmd_verify = ver;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_verify = 1'b1;
        cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'(s + 4'd5);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 64'(sb.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    int b0, r0;

    initial begin
        #2 resetn = 1'b0;
        #1;
        check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check_eq("rst_mem_valid", 64'(mem_valid), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("rst_rsp_status", 64'(rsp_status), 64'd0);
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        // 1: plain write
        b0 = beats;
        issue(1, FSM_CFG_ADDR, 32'h5, 4'hF, 0, 1, ST_OK, 32'h0);
        drain("t1_drain");
        check_eq("t1_config", 64'(fsm_config), 64'h5);
        check_eq("t1_beats", 64'(beats - b0), 64'd1);
        check_eq("t1_run", 64'(last_run), 64'd2);

        // 2: write with verify
        b0 = beats;
        issue(1, FSM_CFG_ADDR, 32'hA, 4'hF, 1, 1, ST_OK, 32'hA);
        drain("t2_drain");
        check_eq("t2_beats", 64'(beats - b0), 64'd2);
        check_eq("t2_gap", 64'(last_gap), 64'd1);
        check_eq("t2_rd_wstrb", 64'(last_wstrb), 64'd0);
        check_eq("t2_rd_wdata", 64'(last_wdata), 64'd0);
        check_eq("t2_config", 64'(fsm_config), 64'hA);

        // 3: forced readback mismatch
        force_rb = 1'b1; force_val = 32'h3;
        issue(1, FSM_CFG_ADDR, 32'hA, 4'hF, 1, 1, ST_MISMATCH, 32'h3);
        drain("t3_drain");
        // bits outside VERIFY_MASK do not matter
        force_val = 32'hFFFF_FFF5;
        issue(1, FSM_CFG_ADDR, 32'h5, 4'hF, 1, 1, ST_OK, 32'hFFFF_FFF5);
        drain("t3b_drain");
        force_rb = 1'b0;
        // lane 0 disabled: nothing left to compare, config unchanged
        issue(1, FSM_CFG_ADDR, 32'hA, 4'b1110, 1, 1, ST_OK, 32'h5);
        drain("t3c_drain");
        check_eq("t3c_config", 64'(fsm_config), 64'h5);

        // 4: timeout, then a normal read with junk write fields
        issue(1, 32'h2000_0000, 32'h1, 4'hF, 0, 1, ST_TIMEOUT, 32'h0);
        drain("t4_drain");
        check_eq("t4_run", 64'(last_run), 64'(TO));
        issue(0, FSM_CFG_ADDR, 32'hDEAD_BEEF, 4'hF, 0, 1, ST_OK, 32'h5);
        drain("t4b_drain");
        check_eq("t4b_rd_wstrb", 64'(last_wstrb), 64'd0);
        check_eq("t4b_rd_wdata", 64'(last_wdata), 64'd0);

        // 5: read (verify ignored) then write, with trailing ready
        trail = 1'b1;
        b0 = beats; r0 = n_rsp;
        issue(0, FSM_CFG_ADDR, 32'h0, 4'h0, 1, 1, ST_OK, 32'h5);
        issue(1, FSM_CFG_ADDR, 32'h6, 4'hF, 0, 1, ST_OK, 32'h0);
        drain("t5_drain");
        trail = 1'b0;
        check_eq("t5_beats", 64'(beats - b0), 64'd2);
        check_eq("t5_rsps", 64'(n_rsp - r0), 64'd2);
        check_eq("t5_gap", 64'(last_gap), 64'd2);
        check_eq("t5_config", 64'(fsm_config), 64'h6);

        // 6a: reset during ACCESS
        issue(1, 32'h2000_0000, 32'h0, 4'hF, 0, 0, ST_OK, 32'h0);
        repeat (3) @(negedge clk);
        check_eq("t6a_busy", 64'(busy), 64'd1);
        check_eq("t6a_valid", 64'(mem_valid), 64'd1);
        #2 resetn = 1'b0;
        #1;
        check_eq("t6a_rst_valid", 64'(mem_valid), 64'd0);
        check_eq("t6a_rst_addr", 64'(mem_addr), 64'd0);
        check_eq("t6a_rst_busy", 64'(busy), 64'd0);
        check_eq("t6a_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        @(posedge clk); @(posedge clk);
        #1 resetn = 1'b1;
        repeat (TO + 4) @(negedge clk);
        check_eq("t6a_no_rsp", 64'(rsp_valid), 64'd0);
        check_eq("t6a_cmd_ready", 64'(cmd_ready), 64'd1);

        // 6b: reset while a response is held in RESP
        rsp_ready = 1'b0;
        issue(0, FSM_CFG_ADDR, 32'h0, 4'h0, 0, 0, ST_OK, 32'h0);
        begin
            int n = 0;
            while (!rsp_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        repeat (3) @(negedge clk);
        check_eq("t6b_held_valid", 64'(rsp_valid), 64'd1);
        check_eq("t6b_held_rdata", 64'(rsp_rdata), 64'h6);
        check_eq("t6b_held_status", 64'(rsp_status), 64'(ST_OK));
        #2 resetn = 1'b0;
        #1;
        check_eq("t6b_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("t6b_rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check_eq("t6b_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        @(posedge clk); @(posedge clk);
        #1 resetn = 1'b1;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("t6b_no_rsp", 64'(rsp_valid), 64'd0);
        check_eq("t6b_cmd_ready", 64'(cmd_ready), 64'd1);

        issue(0, FSM_CFG_ADDR, 32'h0, 4'h0, 0, 1, ST_OK, 32'h6);
        drain("t6c_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
